// File: rtl/processador_param.sv
// rtl/processador_param.sv - multi-cycle fetch/execute core with loadable program memory
// Runs free or one instruction per step edge; results and flags drive the display/LEDs.
module processador_param #(
    parameter int WIDTH = 4,
    parameter int PC_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_mode,
    input  logic                 start,
    input  logic                 step,
    input  logic                 prog_we,
    input  logic [PC_W-1:0]      prog_addr,
    input  logic [WIDTH+7:0]     prog_data,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 neg,
    output logic                 zero,
    output logic [PC_W-1:0]      pc,
    output logic [1:0]           state,
    output logic                 halted,
    output logic                 busy
);
    localparam int IW    = WIDTH + 8;
    localparam int DEPTH = 1 << PC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MUL  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state_q;
    state_t             state_d;
    logic [IW-1:0]      mem [DEPTH];
    logic [IW-1:0]      ir;
    logic [WIDTH-1:0]   regs [4];
    logic               step_q;
    logic               step_rise;

    logic [3:0]         op;
    logic [1:0]         rd_idx;
    logic [1:0]         rs_idx;
    logic [WIDTH-1:0]   imm;
    logic [WIDTH-1:0]   rd_val;
    logic [WIDTH-1:0]   rs_val;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_wr;
    logic [PC_W-1:0]    jmp_target;
    logic [PC_W-1:0]    pc_next;

    assign op         = ir[IW-1 -: 4];
    assign rd_idx     = ir[WIDTH+3 -: 2];
    assign rs_idx     = ir[WIDTH+1 -: 2];
    assign imm        = ir[WIDTH-1:0];
    assign rd_val     = regs[rd_idx];
    assign rs_val     = regs[rs_idx];
    assign sum        = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff       = rd_val - rs_val;
    assign prod       = {{WIDTH{1'b0}}, rd_val} * {{WIDTH{1'b0}}, rs_val};
    assign jmp_target = PC_W'(imm);
    assign step_rise  = step && !step_q;

    always_comb begin
        alu_val = '0;
        alu_wr  = 1'b0;
        case (op)
            OP_ADD: begin alu_val = sum[WIDTH-1:0];  alu_wr = 1'b1; end
            OP_SUB: begin alu_val = diff;            alu_wr = 1'b1; end
            OP_AND: begin alu_val = rd_val & rs_val; alu_wr = 1'b1; end
            OP_OR:  begin alu_val = rd_val | rs_val; alu_wr = 1'b1; end
            OP_XOR: begin alu_val = rd_val ^ rs_val; alu_wr = 1'b1; end
            OP_MUL: begin alu_val = prod[WIDTH-1:0]; alu_wr = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        pc_next = pc + 1'b1;
        if (op == OP_JMP || (op == OP_JZ && zero)) begin
            pc_next = jmp_target;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_HALT)  state_d = ST_IDLE;
                else if (run_mode)  state_d = ST_FETCH;
                else                state_d = ST_WAIT;
            end
            ST_WAIT:  if (step_rise) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Program memory is deliberately outside the reset domain so a board reset keeps the program.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == ST_IDLE || halted)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            ir     <= '0;
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            zero   <= 1'b0;
            halted <= 1'b0;
            step_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            step_q <= step;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pc     <= '0;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: ir <= mem[pc];
                ST_EXEC: begin
                    // HALT freezes pc so the display keeps showing where execution stopped.
                    if (op == OP_HALT) halted <= 1'b1;
                    else               pc     <= pc_next;
                    if (op == OP_LDI) regs[rd_idx] <= imm;
                    if (alu_wr) begin
                        regs[rd_idx] <= alu_val;
                        zero         <= (alu_val == '0);
                    end
                    if (op == OP_ADD) carry  <= sum[WIDTH];
                    if (op == OP_SUB) neg    <= (rs_val > rd_val);
                    if (op == OP_MUL) result <= prod;
                    if (op == OP_OUT) result <= {{WIDTH{1'b0}}, rd_val};
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;
    assign busy  = (state_q != ST_IDLE) && !halted;

endmodule

// File: tb/tb_processador_param.sv
// tb/tb_processador_param.sv - directed bench with an instruction-level reference model
module tb_processador_param;
    localparam int W     = 4;
    localparam int P     = 3;
    localparam int MASK  = 15;
    localparam int DEPTH = 8;
    localparam int S_IDLE = 0, S_FETCH = 1, S_EXEC = 2, S_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run_mode = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_addr = '0;
    logic [11:0] prog_data = '0;
    logic [7:0]  result;
    logic        carry, neg, zero;
    logic [2:0]  pc;
    logic [1:0]  state;
    logic        halted, busy;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    processador_param #(.WIDTH(W), .PC_W(P)) dut (
        .clk(clk), .rst(rst), .run_mode(run_mode), .start(start), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .result(result), .carry(carry), .neg(neg), .zero(zero),
        .pc(pc), .state(state), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: program-visible machine state advanced once per clock.
    logic [11:0] m_mem [DEPTH];
    int m_r [4];
    int m_pc, m_state, m_result, m_carry, m_neg, m_zero, m_halted, m_step_prev;
    logic [11:0] m_ir;

    task automatic model_exec();
        int op, rd, rs, imm, a, b, t, nxt;
        op  = int'(m_ir[11:8]);
        rd  = int'(m_ir[7:6]);
        rs  = int'(m_ir[5:4]);
        imm = int'(m_ir[3:0]);
        a = m_r[rd];
        b = m_r[rs];
        nxt = (m_pc + 1) % DEPTH;
        case (op)
            1:  m_r[rd] = imm;
            2:  begin t = a + b; m_carry = (t > MASK) ? 1 : 0; m_r[rd] = t & MASK; end
            3:  begin m_neg = (b > a) ? 1 : 0; m_r[rd] = (a - b) & MASK; end
            4:  m_r[rd] = a & b;
            5:  m_r[rd] = a | b;
            6:  m_r[rd] = a ^ b;
            7:  begin t = a * b; m_result = t; m_r[rd] = t & MASK; end
            8:  nxt = imm % DEPTH;
            9:  if (m_zero != 0) nxt = imm % DEPTH;
            10: m_result = a;
            default: ;
        endcase
        if (op >= 2 && op <= 7) m_zero = (m_r[rd] == 0) ? 1 : 0;
        if (op == 15) begin
            m_halted = 1;
            m_state  = S_IDLE;
        end else begin
            m_pc    = nxt;
            m_state = run_mode ? S_FETCH : S_WAIT;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 0; m_state = S_IDLE; m_result = 0; m_carry = 0; m_neg = 0;
            m_zero = 0; m_halted = 0; m_step_prev = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
        end else begin
            bit rise;
            if (prog_we && (m_state == S_IDLE || m_halted != 0)) m_mem[prog_addr] = prog_data;
            rise = step && (m_step_prev == 0);
            m_step_prev = step ? 1 : 0;
            case (m_state)
                S_IDLE:  if (start) begin m_pc = 0; m_halted = 0; m_state = S_FETCH; end
                S_FETCH: begin m_ir = m_mem[m_pc]; m_state = S_EXEC; end
                S_EXEC:  model_exec();
                default: if (rise) m_state = S_FETCH;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int exp_vec, busy_m;
            busy_m  = (m_state != S_IDLE && m_halted == 0) ? 1 : 0;
            exp_vec = (m_result << 10) | (m_carry << 9) | (m_neg << 8) | (m_zero << 7) |
                      (m_pc << 4) | (m_state << 2) | (m_halted << 1) | busy_m;
            chk("cycle{result,c,n,z,pc,state,halted,busy}",
                int'({result, carry, neg, zero, pc, state, halted, busy}), exp_vec);
        end
    end

    function automatic logic [11:0] ins(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 4'(imm)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [11:0] d);
        prog_we   = 1'b1;
        prog_addr = 3'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int maxc);
        int n = 0;
        while (!halted && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL wait_halt: halted=0 after %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_jmp [10];
        int seq_wrap [10];
        seq_jmp  = '{0, 1, 2, 3, 4, 5, 6, 7, 2, 3};
        seq_wrap = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

        repeat (2) tick();
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", int'({carry, neg, zero}), 0);
        check_en = 1'b1;
        rst = 1'b1;
        tick();

        // ADD with carry-out to zero, halt timing
        load(0, ins(1, 0, 0, 7));
        load(1, ins(1, 1, 0, 9));
        load(2, ins(2, 0, 1, 0));
        load(3, ins(10, 0, 0, 0));
        load(4, ins(15, 0, 0, 0));
        for (int i = 5; i < 8; i++) load(i, ins(0, 0, 0, 0));
        pulse_start();
        chk("t1_fetch_state", state, 1);
        repeat (9) tick();
        chk("t1_halted_early", halted, 0);
        tick();
        chk("t1_halted_at_10", halted, 1);
        chk("t1_busy", busy, 0);
        chk("t1_result", result, 8'h00);
        chk("t1_carry", carry, 1);
        chk("t1_zero", zero, 1);
        chk("t1_pc", pc, 4);

        // SUB with borrow, JZ not taken
        load(0, ins(1, 0, 0, 3));
        load(1, ins(1, 1, 0, 5));
        load(2, ins(3, 0, 1, 0));
        load(3, ins(10, 0, 0, 0));
        load(4, ins(9, 0, 0, 6));
        load(5, ins(15, 0, 0, 0));
        load(6, ins(15, 0, 0, 0));
        pulse_start();
        wait_halt(100);
        chk("t2_result", result, 8'h0E);
        chk("t2_neg", neg, 1);
        chk("t2_zero", zero, 0);
        chk("t2_pc", pc, 5);

        // full-width MUL
        load(0, ins(1, 2, 0, 15));
        load(1, ins(1, 3, 0, 15));
        load(2, ins(7, 2, 3, 0));
        load(3, ins(15, 0, 0, 0));
        pulse_start();
        wait_halt(100);
        chk("t3_result", result, 8'hE1);
        chk("t3_zero", zero, 0);
        chk("t3_carry_held", carry, 1);
        chk("t3_neg_held", neg, 1);

        // JZ taken; r2 keeps MUL low bits
        load(0, ins(6, 3, 3, 0));
        load(1, ins(9, 0, 0, 5));
        load(2, ins(1, 2, 0, 9));
        load(3, ins(10, 2, 0, 0));
        load(4, ins(15, 0, 0, 0));
        load(5, ins(10, 2, 0, 0));
        load(6, ins(15, 0, 0, 0));
        pulse_start();
        wait_halt(100);
        chk("t3b_result", result, 8'h01);
        chk("t3b_zero", zero, 1);
        chk("t3b_pc", pc, 6);

        // logic ops
        load(0, ins(1, 0, 0, 12));
        load(1, ins(1, 1, 0, 10));
        load(2, ins(4, 0, 1, 0));
        load(3, ins(5, 1, 0, 0));
        load(4, ins(6, 0, 1, 0));
        load(5, ins(10, 0, 0, 0));
        load(6, ins(15, 0, 0, 0));
        pulse_start();
        wait_halt(100);
        chk("t4_result", result, 8'h02);
        chk("t4_zero", zero, 0);

        // single-step mode
        load(0, ins(1, 0, 0, 1));
        load(1, ins(1, 1, 0, 2));
        load(2, ins(2, 0, 1, 0));
        load(3, ins(10, 0, 0, 0));
        run_mode = 1'b0;
        pulse_start();
        repeat (2) tick();
        chk("step_wait_state", state, 3);
        chk("step_pc1", pc, 1);
        step = 1'b1;
        repeat (20) tick();
        step = 1'b0;
        chk("step_held_pc", pc, 2);
        chk("step_held_state", state, 3);
        repeat (2) tick();
        step = 1'b1;
        repeat (4) tick();
        step = 1'b0;
        chk("step_toggle_pc", pc, 3);
        chk("step_toggle_state", state, 3);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        chk("step_discard_pc", pc, 4);
        chk("step_discard_state", state, 3);
        chk("step_result", result, 3);
        run_mode = 1'b1;
        pulse_rst();

        // JMP at last address, then natural wrap
        for (int i = 0; i < 7; i++) load(i, ins(0, 0, 0, 0));
        load(7, ins(8, 0, 0, 2));
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            chk("jmp_pc", pc, seq_jmp[i]);
            chk("jmp_fetch", state, 1);
            repeat (2) tick();
        end
        pulse_rst();
        load(7, ins(0, 0, 0, 0));
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            chk("wrap_pc", pc, seq_wrap[i]);
            repeat (2) tick();
        end
        pulse_rst();

        // write protection while running, reset mid-EXEC
        load(0, ins(10, 1, 0, 0));
        load(1, ins(1, 1, 0, 6));
        load(2, ins(1, 0, 0, 7));
        load(3, ins(2, 0, 1, 0));
        load(4, ins(10, 0, 0, 0));
        load(5, ins(15, 0, 0, 0));
        pulse_start();
        wait_halt(100);
        chk("r_first_result", result, 8'h0D);
        pulse_start();
        prog_we   = 1'b1;
        prog_addr = 3'd0;
        prog_data = ins(15, 0, 0, 0);
        tick();
        prog_we = 1'b0;
        tick();
        chk("r_out_r1", result, 8'h06);
        repeat (5) tick();
        chk("r_exec_state", state, 2);
        chk("r_exec_pc", pc, 3);
        rst = 1'b0;
        #1;
        chk("r_async_state", state, 0);
        chk("r_async_pc", pc, 0);
        chk("r_async_halted", halted, 0);
        chk("r_async_result", result, 0);
        tick();
        rst = 1'b1;
        pulse_start();
        repeat (2) tick();
        chk("r_regs_cleared", result, 0);
        chk("r_not_halted", halted, 0);
        wait_halt(100);
        chk("r_intact_result", result, 8'h0D);
        chk("r_intact_pc", pc, 5);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
